// File: rtl/tree_engine_arbiter.sv
// Round-robin sequencer sharing one isolation-tree engine between NUM_CH channels.
// Optional per-channel anomaly counters are enabled by defining TREE_ARB_ANOMALY_CNT_EN.
module tree_engine_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]            ch_ack,
    output logic [DATA_WIDTH-1:0]        eng_data,
    output logic                         eng_valid,
    input  logic                         eng_processed,
    input  logic                         eng_anomaly,
    output logic                         res_valid,
    output logic [$clog2(NUM_CH)-1:0]    res_ch,
    output logic                         res_anomaly,
    output logic                         res_timeout,
    output logic                         busy
`ifdef TREE_ARB_ANOMALY_CNT_EN
    ,
    input  logic [$clog2(NUM_CH)-1:0]    cnt_sel,
    input  logic                         cnt_clr,
    output logic [15:0]                  cnt_value
`endif
);

    localparam int CW = $clog2(NUM_CH);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t                  r_state, w_state_next;
    logic [CW-1:0]           r_rr_ptr, r_grant;
    logic [15:0]             r_wdog;
    logic [DATA_WIDTH-1:0]   r_eng_data;
    logic                    r_eng_valid;
    logic [NUM_CH-1:0]       r_ack;
    logic                    r_res_valid, r_res_anomaly, r_res_timeout;
    logic [CW-1:0]           r_res_ch;

    logic [NUM_CH-1:0]       w_req;
    logic                    w_gnt_found;
    logic [CW-1:0]           w_gnt_idx;
    logic [DATA_WIDTH-1:0]   w_ch_data [NUM_CH];

    assign w_req = ch_valid & ch_enable;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_data
        assign w_ch_data[gi] = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotating search starting just after the last served channel.
    always_comb begin
        int            idx;
        logic [CW-1:0] cand;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        idx         = 0;
        cand        = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = CW'(idx);
            if (!w_gnt_found && w_req[cand]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_gnt_found) w_state_next = ST_BUSY;
            ST_BUSY: if (eng_processed || (r_wdog == TMO_LAST)) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= CW'(NUM_CH - 1);
            r_grant       <= '0;
            r_wdog        <= '0;
            r_eng_data    <= '0;
            r_eng_valid   <= 1'b0;
            r_ack         <= '0;
            r_res_valid   <= 1'b0;
            r_res_ch      <= '0;
            r_res_anomaly <= 1'b0;
            r_res_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ack         <= '0;
            r_res_valid   <= 1'b0;
            r_res_ch      <= '0;
            r_res_anomaly <= 1'b0;
            r_res_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_found) begin
                        r_grant     <= w_gnt_idx;
                        r_eng_data  <= w_ch_data[w_gnt_idx];
                        r_eng_valid <= 1'b1;
                        r_wdog      <= '0;
                    end
                end
                ST_BUSY: begin
                    r_wdog <= r_wdog + 16'd1;
                    if (w_state_next == ST_DONE) begin
                        // A processed pulse on the final watchdog cycle still counts as a real result.
                        r_eng_valid      <= 1'b0;
                        r_eng_data       <= '0;
                        r_ack[r_grant]   <= 1'b1;
                        r_res_valid      <= 1'b1;
                        r_res_ch         <= r_grant;
                        r_res_anomaly    <= eng_processed & eng_anomaly;
                        r_res_timeout    <= ~eng_processed;
                    end
                end
                ST_DONE: begin
                    r_rr_ptr <= r_grant;
                    r_wdog   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ch_ack      = r_ack;
    assign eng_data    = r_eng_data;
    assign eng_valid   = r_eng_valid;
    assign res_valid   = r_res_valid;
    assign res_ch      = r_res_ch;
    assign res_anomaly = r_res_anomaly;
    assign res_timeout = r_res_timeout;
    assign busy        = (r_state != ST_IDLE);

`ifdef TREE_ARB_ANOMALY_CNT_EN
    logic [15:0] w_cnt [NUM_CH];
    logic [15:0] r_cnt_value;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
        logic [15:0] r_cnt;
        // Clear takes precedence over a coincident increment; count saturates at all-ones.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (cnt_clr && (cnt_sel == CW'(gi))) begin
                r_cnt <= '0;
            end else if (r_res_valid && r_res_anomaly && (r_res_ch == CW'(gi))
                         && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign w_cnt[gi] = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) r_cnt_value <= '0;
        else       r_cnt_value <= w_cnt[cnt_sel];
    end

    assign cnt_value = r_cnt_value;
`endif

endmodule

// File: tb/tb_tree_engine_arbiter.sv
// Directed bench for tree_engine_arbiter: reset, single request, round-robin, masking, watchdog, reset abort.
module tb_tree_engine_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    ch_enable, ch_valid, ch_ack;
    logic [31:0]   ch_data;
    logic [7:0]    eng_data;
    logic          eng_valid, eng_processed, eng_anomaly;
    logic          res_valid, res_anomaly, res_timeout, busy;
    logic [1:0]    res_ch;
`ifdef TREE_ARB_ANOMALY_CNT_EN
    logic [1:0]    cnt_sel;
    logic          cnt_clr;
    logic [15:0]   cnt_value;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] dat [4] = '{8'hAA, 8'hBB, 8'h5A, 8'hDD};

    always #5 clk = ~clk;

    tree_engine_arbiter #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .ch_enable(ch_enable), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ack(ch_ack), .eng_data(eng_data), .eng_valid(eng_valid),
        .eng_processed(eng_processed), .eng_anomaly(eng_anomaly),
        .res_valid(res_valid), .res_ch(res_ch), .res_anomaly(res_anomaly),
        .res_timeout(res_timeout), .busy(busy)
`ifdef TREE_ARB_ANOMALY_CNT_EN
        , .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_value(cnt_value)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle with a request pending; models a 1-cycle engine.
    task automatic run_txn(input int ch, input logic anom, input logic [3:0] en_mid);
        step();
        chk("busy_eng_valid", 32'(eng_valid), 32'd1);
        chk("busy_eng_data", 32'(eng_data), 32'(dat[ch]));
        ch_enable     = en_mid;
        eng_processed = 1'b1;
        eng_anomaly   = anom;
        step();
        eng_processed = 1'b0;
        eng_anomaly   = 1'b0;
        chk("done_ack", 32'(ch_ack), 32'(1) << ch);
        chk("done_res_valid", 32'(res_valid), 32'd1);
        chk("done_res_ch", 32'(res_ch), 32'(ch));
        chk("done_res_anomaly", 32'(res_anomaly), 32'(anom));
        chk("done_res_timeout", 32'(res_timeout), 32'd0);
        chk("done_eng_data_zero", 32'(eng_data), 32'd0);
        step();
        chk("idle_ack", 32'(ch_ack), 32'd0);
        chk("idle_res_valid", 32'(res_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ch_enable = 4'hF; ch_valid = 4'h0;
        ch_data = {dat[3], dat[2], dat[1], dat[0]};
        eng_processed = 1'b0; eng_anomaly = 1'b0;
`ifdef TREE_ARB_ANOMALY_CNT_EN
        cnt_sel = 2'd0; cnt_clr = 1'b0;
`endif
        step(); step();
        chk("rst_ack", 32'(ch_ack), 32'd0);
        chk("rst_eng_valid", 32'(eng_valid), 32'd0);
        chk("rst_eng_data", 32'(eng_data), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single request on ch2, engine answers 2 cycles after eng_valid.
        reset = 1'b0; ch_valid = 4'b0100;
        step();
        chk("t1_eng_valid", 32'(eng_valid), 32'd1);
        chk("t1_eng_data", 32'(eng_data), 32'h5A);
        step();
        chk("t1_no_early_ack", 32'(ch_ack), 32'd0);
        ch_data = 32'h0;
        step();
        chk("t1_data_held", 32'(eng_data), 32'h5A);
        eng_processed = 1'b1; eng_anomaly = 1'b1;
        step();
        eng_processed = 1'b0; eng_anomaly = 1'b0; ch_valid = 4'b0000;
        ch_data = {dat[3], dat[2], dat[1], dat[0]};
        chk("t1_ack", 32'(ch_ack), 32'b0100);
        chk("t1_res_valid", 32'(res_valid), 32'd1);
        chk("t1_res_ch", 32'(res_ch), 32'd2);
        chk("t1_res_anomaly", 32'(res_anomaly), 32'd1);
        chk("t1_eng_valid_low", 32'(eng_valid), 32'd0);
        step();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_res_ch", 32'(res_ch), 32'd0);

        // Round-robin from reset: 0,1,2,3,0 with all channels requesting.
        reset = 1'b1;
        step();
        reset = 1'b0; ch_valid = 4'b1111;
        run_txn(0, 1'b0, 4'hF);
        run_txn(1, 1'b1, 4'hF);
        run_txn(2, 1'b0, 4'hF);
        run_txn(3, 1'b1, 4'hF);
        run_txn(0, 1'b0, 4'hF);
        ch_valid = 4'b0000;

        // Masking: ch0 disabled is skipped twice, then enabled mid-BUSY and served next.
        ch_enable = 4'b0010; ch_valid = 4'b0011;
        run_txn(1, 1'b1, 4'b0010);
        run_txn(1, 1'b0, 4'b0011);
        run_txn(0, 1'b1, 4'b0011);
        ch_valid = 4'b0000; ch_enable = 4'hF;

        // Watchdog abort on ch3; anomaly line high but not sampled.
        ch_valid = 4'b1000; eng_anomaly = 1'b1;
        for (int k = 1; k <= TMO; k++) begin
            step();
            chk("wd_busy_eng_valid", 32'(eng_valid), 32'd1);
            chk("wd_busy_no_res", 32'(res_valid), 32'd0);
        end
        step();
        ch_valid = 4'b0000; eng_anomaly = 1'b0;
        chk("wd_ack", 32'(ch_ack), 32'b1000);
        chk("wd_res_ch", 32'(res_ch), 32'd3);
        chk("wd_res_timeout", 32'(res_timeout), 32'd1);
        chk("wd_res_anomaly", 32'(res_anomaly), 32'd0);
        step();
        chk("wd_idle_busy", 32'(busy), 32'd0);

        // Processed on the last watchdog cycle wins over timeout.
        ch_valid = 4'b0001;
        for (int k = 1; k <= TMO; k++) begin
            step();
            chk("wd2_busy_eng_valid", 32'(eng_valid), 32'd1);
            if (k == TMO) begin
                eng_processed = 1'b1; eng_anomaly = 1'b1;
            end
        end
        step();
        eng_processed = 1'b0; eng_anomaly = 1'b0; ch_valid = 4'b0000;
        chk("wd2_ack", 32'(ch_ack), 32'b0001);
        chk("wd2_res_timeout", 32'(res_timeout), 32'd0);
        chk("wd2_res_anomaly", 32'(res_anomaly), 32'd1);
        step();

        // Reset during third BUSY cycle discards the sample; ch0 wins afterwards.
        ch_valid = 4'b0010;
        step();
        chk("rb_eng_data", 32'(eng_data), 32'hBB);
        step(); step();
        reset = 1'b1;
        step();
        chk("rb_ack", 32'(ch_ack), 32'd0);
        chk("rb_res_valid", 32'(res_valid), 32'd0);
        chk("rb_eng_valid", 32'(eng_valid), 32'd0);
        chk("rb_eng_data_zero", 32'(eng_data), 32'd0);
        chk("rb_busy", 32'(busy), 32'd0);
        reset = 1'b0; ch_valid = 4'b1001;
        run_txn(0, 1'b0, 4'hF);
        ch_valid = 4'b0000;

        // Processed pulse while idle is ignored.
        eng_processed = 1'b1; eng_anomaly = 1'b1;
        step();
        eng_processed = 1'b0; eng_anomaly = 1'b0;
        chk("idle_proc_res_valid", 32'(res_valid), 32'd0);
        chk("idle_proc_busy", 32'(busy), 32'd0);
        step();
        chk("idle_proc_ack", 32'(ch_ack), 32'd0);

`ifdef TREE_ARB_ANOMALY_CNT_EN
        ch_valid = 4'b0010;
        run_txn(1, 1'b1, 4'hF);
        run_txn(1, 1'b1, 4'hF);
        run_txn(1, 1'b1, 4'hF);
        ch_valid = 4'b0000;
        cnt_sel = 2'd1;
        step(); step();
        chk("cnt_ch1", 32'(cnt_value), 32'd3);
        cnt_sel = 2'd0;
        step(); step();
        chk("cnt_ch0", 32'(cnt_value), 32'd0);
        cnt_sel = 2'd1; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        step();
        chk("cnt_ch1_cleared", 32'(cnt_value), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tree_engine_arbiter.md
Name: tree_engine_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one isolation-tree evaluation engine between NUM_CH independent sensor channels.
- Sits between per-channel input buffers (valid/processed handshake) and the single tree state machine.
- Latches the granted sample, holds it on the engine, and waits for the engine's processed pulse.
- Routes the anomaly result back as a channel-tagged pulse; a watchdog aborts a hung engine.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8)
- DATA_WIDTH, 8, sample width
- TIMEOUT_CYCLES, 255, max BUSY cycles before abort (1..65535)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ch_enable  input  NUM_CH  per-channel request mask; 0 = channel never granted
- ch_valid  input  NUM_CH  per-channel sample valid; held until matching ch_ack
- ch_data  input  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- ch_ack  output  NUM_CH  one-hot, one-cycle pulse; channel's sample retired
- eng_data  output  DATA_WIDTH  latched sample to engine
- eng_valid  output  1  high throughout BUSY
- eng_processed  input  1  engine done pulse
- eng_anomaly  input  1  engine verdict; sampled only when eng_processed=1
- res_valid  output  1  one-cycle result pulse
- res_ch  output  $clog2(NUM_CH)  channel of result
- res_anomaly  output  1  verdict for res_ch
- res_timeout  output  1  result was a watchdog abort (res_anomaly=0)
- busy  output  1  state != IDLE

Behaviour:
- Reset: state=IDLE; rr_ptr=NUM_CH-1 (ch0 highest priority first); all outputs 0; watchdog=0.
- Request vector req = ch_valid & ch_enable.
- IDLE: if req!=0, grant first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH. Latch grant index and that channel's data; go to BUSY next cycle. Otherwise stay in IDLE.
- BUSY:
  - eng_valid=1; eng_data holds the latched value; watchdog increments each cycle.
  - eng_processed=1: capture eng_anomaly, go to DONE.
  - Else, if watchdog == TIMEOUT_CYCLES-1: go to DONE with the timeout flag set.
  - eng_processed and timeout in the same cycle: processed wins, timeout flag stays 0.
- DONE (one cycle):
  - ch_ack[grant]=1, res_valid=1, res_ch=grant, res_anomaly/res_timeout per capture.
  - rr_ptr=grant; watchdog cleared; go to IDLE.
- Latency: req seen in IDLE at cycle t -> eng_valid at t+1. eng_processed at cycle u -> ack/result at u+1 -> IDLE at u+2. Minimum 3 cycles per sample with a 1-cycle engine.
- ch_data/ch_valid changes after grant are ignored. Granted channel dropping ch_valid mid-BUSY still gets its ack.
- ch_enable cleared during BUSY does not abort the transaction; it only affects the next arbitration.
- eng_processed outside BUSY is ignored.
- eng_valid, eng_data, res_* are registered outputs. eng_data is 0 when not BUSY; res_ch/res_anomaly/res_timeout are 0 when res_valid=0.
- Reset asserted in any state: next cycle is IDLE with reset values, no ack and no result pulse. A partially processed sample is discarded and the channel must re-request.
- Fairness: a continuously requesting channel waits at most NUM_CH-1 transactions.

Optional Feature:
- Macro TREE_ARB_ANOMALY_CNT_EN.
- Defined:
  - Adds ports cnt_sel (input, $clog2(NUM_CH)), cnt_clr (input, 1), cnt_value (output, 16).
  - Per-channel 16-bit saturating counters increment on res_valid & res_anomaly; saturate at 0xFFFF.
  - cnt_value = registered count of channel cnt_sel, one-cycle read latency.
  - cnt_clr zeroes the selected counter. Clear in the same cycle as an increment to that counter: clear wins.
  - Counters reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single request: NUM_CH=4, ch_valid=0b0100, data 0x5A; engine pulses processed 2 cycles after eng_valid with anomaly=1 -> eng_data=0x5A; ch_ack=0b0100 and res_valid, res_ch=2, res_anomaly=1 exactly 1 cycle after processed.
- Round-robin: ch_valid=0b1111 held, 1-cycle engine -> grant order 0,1,2,3,0; ack spacing 3 cycles.
- Masking/fairness: ch_valid=0b0011, ch_enable=0b0010 -> only ch1 served. Enable ch0 mid-BUSY -> next grant is ch0.
- Watchdog: TIMEOUT_CYCLES=8, engine never responds -> after 8 BUSY cycles, res_timeout=1, res_anomaly=0, ack pulses. processed arriving on the 8th cycle -> res_timeout=0.
- Reset mid-BUSY: reset during cycle 3 of BUSY -> no ack, outputs 0; after reset, ch0 is granted first from req=0b1001.
- With TREE_ARB_ANOMALY_CNT_EN: 3 anomalies on ch1 -> cnt_sel=1 reads 3. cnt_clr -> 0. Preload 0xFFFF then one more anomaly -> stays 0xFFFF.
